// File: rtl/uart_tx_fifo.sv
// Byte FIFO ahead of the UART controller: first-word-fall-through valid/ready
// output, occupancy counter, and a sticky flag for bytes dropped while full.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       wr_i,
    output logic                       full_o,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    count_nxt;
    logic             push;
    logic             pop;
    logic             drop;

    // A pop frees a slot in the same edge, so a write to a full FIFO is
    // still accepted when the consumer is taking the head byte.
    always_comb begin
        pop  = valid_o & ready_i;
        push = wr_i & (~full_o | pop);
        drop = wr_i & full_o & ~pop;
        count_nxt = count_o;
        case ({push, pop})
            2'b10:   count_nxt = count_o + CW'(1);
            2'b01:   count_nxt = count_o - CW'(1);
            default: count_nxt = count_o;
        endcase
    end

    // Status flags are flopped from the next count so they change on the
    // same edge as the occupancy and never depend on wr_i combinationally.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wp         <= '0;
            rp         <= '0;
            count_o    <= '0;
            full_o     <= 1'b0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            count_o <= count_nxt;
            full_o  <= (count_nxt == CW'(DEPTH));
            valid_o <= (count_nxt != '0);
            if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && push) begin
            mem[wp] <= data_i;
        end
    end

    assign data_o = mem[rp];

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             flush_i = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic             wr_i = 1'b0;
    logic             ready_i = 1'b0;
    logic             full_o;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic [CW-1:0]    count_o;
    logic             overflow_o;

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .data_i     (data_i),
        .wr_i       (wr_i),
        .full_o     (full_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] mq[$];
    logic [7:0] plog[$];
    logic       mov = 1'b0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic step(input logic r, input logic f, input logic w,
                        input logic [7:0] d, input logic rd);
        bit do_pop, is_full, do_push;
        rst_i = r; flush_i = f; wr_i = w; data_i = d; ready_i = rd;
        do_pop  = (mq.size() != 0) && rd;
        is_full = (mq.size() == DEPTH);
        do_push = w && (!is_full || do_pop);
        @(posedge clk_i);
        #1;
        if (r || f) begin
            mq.delete();
            mov = 1'b0;
        end else begin
            if (do_pop) plog.push_back(mq.pop_front());
            if (do_push) mq.push_back(d);
            if (w && !do_push) mov = 1'b1;
        end
        chk("count", 32'(count_o), 32'(mq.size()));
        chk("valid", 32'(valid_o), 32'(mq.size() != 0));
        chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
        chk("overflow", 32'(overflow_o), 32'(mov));
        if (mq.size() != 0) chk("data", 32'(data_o), 32'(mq[0]));
    endtask

    initial begin
        int sent;
        logic w;

        // Reset
        step(1, 0, 0, 8'h00, 0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);

        // Three pushes with ready low, then drain
        step(0, 0, 1, 8'h41, 0); chk("cnt1", 32'(count_o), 32'd1);
        step(0, 0, 1, 8'h42, 0); chk("cnt2", 32'(count_o), 32'd2);
        step(0, 0, 1, 8'h43, 0); chk("cnt3", 32'(count_o), 32'd3);
        chk("head41", 32'(data_o), 32'h41);
        plog.delete();
        repeat (3) step(0, 0, 0, 8'h00, 1);
        chk("pop_n", 32'(plog.size()), 32'd3);
        chk("pop41", 32'(plog[0]), 32'h41);
        chk("pop42", 32'(plog[1]), 32'h42);
        chk("pop43", 32'(plog[2]), 32'h43);
        chk("empty_valid", 32'(valid_o), 32'd0);

        // Fill, drop one, drain
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'(i), 0);
        chk("fill_full", 32'(full_o), 32'd1);
        step(0, 0, 1, 8'hFF, 0);
        chk("drop_ovf", 32'(overflow_o), 32'd1);
        chk("drop_cnt", 32'(count_o), 32'd16);
        plog.delete();
        repeat (17) step(0, 0, 0, 8'h00, 1);
        chk("drain_n", 32'(plog.size()), 32'd16);
        for (int i = 0; i < 16; i++) chk("drain_seq", 32'(plog[i]), 32'(i));

        // Write while full with simultaneous pop
        step(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'(i), 0);
        plog.delete();
        step(0, 0, 1, 8'h55, 1);
        chk("fp_pop", 32'(plog[0]), 32'h00);
        chk("fp_cnt", 32'(count_o), 32'd16);
        chk("fp_ovf", 32'(overflow_o), 32'd0);
        repeat (17) step(0, 0, 0, 8'h00, 1);
        chk("fp_n", 32'(plog.size()), 32'd17);
        chk("fp_last", 32'(plog[plog.size()-1]), 32'h55);

        // Wrap stream, never full
        plog.delete();
        sent = 0;
        for (int c = 0; c < 2000 && (sent < 40 || mq.size() != 0); c++) begin
            w = (sent < 40) && (mq.size() < DEPTH - 1) && ($urandom_range(0, 3) != 0);
            step(0, 0, w, 8'(sent), 1'($urandom_range(0, 1)));
            if (w) sent++;
        end
        chk("wrap_n", 32'(plog.size()), 32'd40);
        for (int i = 0; i < 40; i++) chk("wrap_seq", 32'(plog[i]), 32'(i));

        // Single byte fall-through with ready held high
        step(0, 0, 1, 8'h21, 1);
        chk("ft_valid", 32'(valid_o), 32'd1);
        chk("ft_data", 32'(data_o), 32'h21);
        step(0, 0, 0, 8'h00, 1);
        chk("ft_gone", 32'(valid_o), 32'd0);

        // Flush with write while overflow set and 5 queued
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'(8'h80 + i), 0);
        step(0, 0, 1, 8'hEE, 0);
        repeat (11) step(0, 0, 0, 8'h00, 1);
        chk("pre_fl_cnt", 32'(count_o), 32'd5);
        chk("pre_fl_ovf", 32'(overflow_o), 32'd1);
        step(0, 1, 1, 8'h99, 0);
        chk("fl_cnt", 32'(count_o), 32'd0);
        chk("fl_valid", 32'(valid_o), 32'd0);
        chk("fl_ovf", 32'(overflow_o), 32'd0);
        step(0, 0, 0, 8'h00, 0);
        chk("fl_nostore", 32'(valid_o), 32'd0);

        // Random soak
        for (int c = 0; c < 400; c++) begin
            step(0, 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 2) != 0),
                 8'($urandom), 1'($urandom_range(0, 2) == 0));
        end

        // Reset mid-stream
        step(1, 0, 1, 8'h77, 1);
        chk("rst2_valid", 32'(valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
